// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register-file debug port and streams {index, value} words over valid/ready, optionally only changed registers
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 31,
  parameter bit DELTA_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_delta,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_value,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SAMPLE, EMIT, DONE} state_t;
  state_t state;
  logic [4:0] ptr;
  logic delta;
  logic [31:0] shadow [32];
  logic [31:0] shadow_valid;
  logic at_last, skip;
  assign at_last = ptr == 5'(LAST_REG);
  assign skip = delta && shadow_valid[ptr] && shadow[ptr] == rf_data;
  assign rf_addr = state == SAMPLE ? ptr : 5'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 5'(FIRST_REG);
      delta <= 1'b0;
      shadow_valid <= '0;
      out_valid <= 1'b0;
      out_idx <= 5'd0;
      out_value <= 32'd0;
      out_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ptr <= 5'(FIRST_REG);
          delta <= mode_delta && DELTA_EN;
          busy <= 1'b1;
          state <= SAMPLE;
        end
        SAMPLE: if (skip) begin
          if (at_last) begin
            state <= DONE;
            done <= 1'b1;
          end else ptr <= ptr + 5'd1;
        end else begin
          shadow_valid[ptr] <= 1'b1;
          out_idx <= ptr;
          out_value <= rf_data;
          out_last <= at_last;
          out_valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (at_last) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            ptr <= ptr + 5'd1;
            state <= SAMPLE;
          end
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) if (DELTA_EN && state == SAMPLE && !skip) shadow[ptr] <= rf_data;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed plus randomized dumps checked against a queue-based reference model
module tb_regfile_dump_reader;
  logic clk = 0, rst = 0, start = 0, mode_delta = 0, out_ready = 1;
  logic [4:0] rf_addr, out_idx;
  logic [31:0] rf_data, out_value;
  logic out_valid, out_last, busy, done;
  logic [31:0] mem [32];
  logic [31:0] m_sh [32];
  bit m_sv [32];
  typedef struct {logic [4:0] idx; logic [31:0] val; logic last;} word_t;
  word_t exp_q[$], got_q[$];
  int checks = 0, errors = 0, dones, first_c, done_c;

  always #5 clk = ~clk;
  assign rf_data = rf_addr == 5'd0 ? 32'd0 : mem[rf_addr];

  regfile_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .mode_delta(mode_delta),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_value(out_value), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_dump(input string nm, input bit dl, input int stall_idx, input int stall_n,
                          input int hook_idx, input logic [31:0] hook_val, input int extra_at);
    logic [31:0] v;
    logic [36:0] held;
    int left;
    bit hooked;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 32; i++) begin
      v = i == 0 ? 32'd0 : i == hook_idx ? hook_val : mem[i];
      if (!dl || !m_sv[i] || m_sh[i] != v) exp_q.push_back('{5'(i), v, i == 31});
      m_sh[i] = v;
      m_sv[i] = 1;
    end
    dones = 0; first_c = -1; done_c = -1; left = stall_n; hooked = 0; held = '0;
    mode_delta = dl; start = 1;
    @(posedge clk); #1;
    start = 0; mode_delta = 0;
    chk({nm, "_busy_start"}, busy, 1);
    for (int c = 1; c < 300 && done_c < 0; c++) begin
      start = (c == extra_at);
      if (out_valid && first_c < 0) first_c = c;
      if (done) begin dones++; done_c = c; end
      if (stall_idx >= 0 && out_valid && out_idx == 5'(stall_idx) && left > 0) begin
        out_ready = 0;
        if (left == stall_n) held = {out_idx, out_value};
        else chk({nm, "_stall_hold"}, {out_idx, out_value}, held);
        left--;
      end else begin
        out_ready = 1;
        if (out_valid) got_q.push_back('{out_idx, out_value, out_last});
      end
      if (!hooked && hook_idx >= 0 && rf_addr == 5'(hook_idx)) begin
        hooked = 1;
        @(negedge clk);
        mem[hook_idx] = hook_val;
      end
      @(posedge clk); #1;
    end
    start = 0;
    chk({nm, "_busy_after_done"}, busy, 0);
    repeat (3) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk({nm, "_done_pulses"}, dones, 1);
    chk({nm, "_nwords"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) begin
      chk($sformatf("%s_w%0d_idx", nm, i), got_q[i].idx, exp_q[i].idx);
      chk($sformatf("%s_w%0d_val", nm, i), got_q[i].val, exp_q[i].val);
      chk($sformatf("%s_w%0d_last", nm, i), got_q[i].last, exp_q[i].last);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'(i * 'h11);
      m_sv[i] = 0;
      m_sh[i] = 0;
    end
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    @(posedge clk); #1;

    run_dump("t1", 0, -1, 0, -1, 0, 0);
    chk("t1_first_valid_cycle", first_c, 2);
    chk("t1_done_cycle", done_c, 65);

    run_dump("t2", 0, 3, 5, -1, 0, 0);

    mem[7] = 32'hDEADBEEF;
    run_dump("t3", 1, -1, 0, -1, 0, 0);

    run_dump("t4", 1, -1, 0, -1, 0, 0);
    chk("t4_done_cycle", done_c, 33);

    start = 1; mode_delta = 0;
    @(posedge clk); #1;
    start = 0; out_ready = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_stuck_valid", out_valid, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t5_valid_after_rst", out_valid, 0);
    chk("t5_busy_after_rst", busy, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_no_done_%0d", k), done, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    for (int i = 0; i < 32; i++) m_sv[i] = 0;
    run_dump("t5", 1, -1, 0, -1, 0, 0);

    run_dump("t6", 1, -1, 0, 5, 32'hCAFE0005, 10);

    for (int k = 0; k < 4; k++) begin
      for (int r = 1; r < 32; r++)
        if ($urandom_range(0, 3) == 0) mem[r] = $urandom_range(0, 1) ? mem[r] : $urandom;
      run_dump($sformatf("t7_%0d", k), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(1, 4)), -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
